buyruk_onbellegi: RTL and testbench

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction requests. It takes the fetch address and request strobe, and returns a 32-bit aligned instruction word with a ready pulse. Misses are filled from next-level memory through a single-request, multi-beat burst port. It sits between the fetch stage and the memory/bus interface.

---
 rtl/buyruk_onbellegi_pkg.sv | 14 +
 rtl/buyruk_onbellegi_dizisi.sv | 54 +++++
 rtl/buyruk_onbellegi.sv | 132 +++++++++++++
 tb/tb_buyruk_onbellegi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/buyruk_onbellegi_pkg.sv
// buyruk_onbellegi_pkg: shared states, constants and address-field widths for the instruction cache
package buyruk_onbellegi_pkg;
    typedef enum logic [1:0] {BOSTA, ISTEK, DOLDUR, YANIT} durum_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    function automatic int ob_genislik(input int satir_kelime);
        return $clog2(4 * satir_kelime);
    endfunction
    function automatic int indis_genislik(input int satir_sayisi);
        return $clog2(satir_sayisi);
    endfunction
    function automatic int etiket_genislik(input int satir_sayisi, input int satir_kelime);
        return 32 - $clog2(4 * satir_kelime) - $clog2(satir_sayisi);
    endfunction
endpackage

// File: rtl/buyruk_onbellegi_dizisi.sv
// onbellek_dizisi: tag, valid and data storage with async read, sync write and invalidate-all
module onbellek_dizisi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int SATIR_SAYISI = 64,
    parameter int SATIR_KELIME = 4,
    localparam int IW = indis_genislik(SATIR_SAYISI),
    localparam int OW = ob_genislik(SATIR_KELIME) - 2,
    localparam int TW = etiket_genislik(SATIR_SAYISI, SATIR_KELIME)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          gecersiz_i,
    input  logic [IW-1:0] oku_indis_i,
    input  logic [OW-1:0] oku_ofset_i,
    output logic [TW-1:0] oku_etiket_o,
    output logic          oku_gecerli_o,
    output logic [31:0]   oku_kelime_o,
    input  logic [IW-1:0] yaz_indis_i,
    input  logic [OW-1:0] yaz_ofset_i,
    input  logic          kelime_yaz_i,
    input  logic [31:0]   yaz_veri_i,
    input  logic          etiket_yaz_i,
    input  logic [TW-1:0] yaz_etiket_i,
    input  logic          gecerli_ayarla_i
);
    logic [TW-1:0]           etiketler [SATIR_SAYISI];
    logic [31:0]             veriler [SATIR_SAYISI*SATIR_KELIME];
    logic [SATIR_SAYISI-1:0] gecerli;

    assign oku_etiket_o  = etiketler[oku_indis_i];
    assign oku_gecerli_o = gecerli[oku_indis_i];
    assign oku_kelime_o  = veriler[{oku_indis_i, oku_ofset_i}];

    // valid bits: invalidate beats a same-cycle line completion
    always_ff @(posedge clk_i) begin
        if (rst_i || gecersiz_i)
            gecerli <= '0;
        else if (etiket_yaz_i && gecerli_ayarla_i)
            gecerli[yaz_indis_i] <= 1'b1;
    end

    // tag written once the last beat of a line lands
    always_ff @(posedge clk_i) begin
        if (etiket_yaz_i)
            etiketler[yaz_indis_i] <= yaz_etiket_i;
    end

    // data words written beat by beat during a fill
    always_ff @(posedge clk_i) begin
        if (kelime_yaz_i)
            veriler[{yaz_indis_i, yaz_ofset_i}] <= yaz_veri_i;
    end
endmodule

// File: rtl/buyruk_onbellegi.sv
// buyruk_onbellegi: direct-mapped read-only instruction cache with burst line fill
module buyruk_onbellegi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int SATIR_SAYISI = 64,
    parameter int SATIR_KELIME = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] buyruk_adres_i,
    input  logic        ps_guncellendi_i,
    input  logic        durdur_i,
    input  logic        onbellek_gecersiz_i,
    output logic [31:0] buyruk_o,
    output logic        buyruk_hazir_o,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic        bellek_gecerli_i,
    input  logic [31:0] bellek_veri_i
);
    localparam int OB = ob_genislik(SATIR_KELIME);
    localparam int IW = indis_genislik(SATIR_SAYISI);
    localparam int OW = OB - 2;
    localparam int TW = etiket_genislik(SATIR_SAYISI, SATIR_KELIME);

    durum_t        durum_q, durum_d;
    logic          bekleyen_v_q;
    logic [31:0]   bekleyen_adres_q, kacirma_adres_q, buyruk_q;
    logic [OW-1:0] sayac_q;
    logic          gecersiz_bayrak_q, iptal_q, hazir_q;
    logic [TW-1:0] okunan_etiket;
    logic          okunan_gecerli;
    logic [31:0]   okunan_kelime;
    logic          unused_bitler;

    wire         istek_al   = (ps_guncellendi_i || bekleyen_v_q) && !durdur_i && durum_q == BOSTA;
    wire [31:0]  arama_adres = bekleyen_v_q ? bekleyen_adres_q : buyruk_adres_i;
    wire [31:0]  dizi_adres  = durum_q == BOSTA ? arama_adres : kacirma_adres_q;
    wire         isabet      = okunan_gecerli && okunan_etiket == dizi_adres[31:OB+IW] && !onbellek_gecersiz_i;
    wire         kelime_yaz  = durum_q == DOLDUR && bellek_gecerli_i;
    wire         son_vurus   = kelime_yaz && sayac_q == OW'(SATIR_KELIME - 1);
    wire [31:0]  iletilen    = kacirma_adres_q[OB-1:2] == sayac_q ? bellek_veri_i : okunan_kelime;

    assign unused_bitler  = ^dizi_adres[1:0];
    assign buyruk_o       = buyruk_q;
    assign buyruk_hazir_o = hazir_q && !(durum_q == YANIT && ps_guncellendi_i);
    assign bellek_adres_o = {kacirma_adres_q[31:OB], {OB{1'b0}}};

    onbellek_dizisi #(
        .SATIR_SAYISI(SATIR_SAYISI),
        .SATIR_KELIME(SATIR_KELIME)
    ) u_dizi (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .gecersiz_i      (onbellek_gecersiz_i),
        .oku_indis_i     (dizi_adres[OB+IW-1:OB]),
        .oku_ofset_i     (dizi_adres[OB-1:2]),
        .oku_etiket_o    (okunan_etiket),
        .oku_gecerli_o   (okunan_gecerli),
        .oku_kelime_o    (okunan_kelime),
        .yaz_indis_i     (kacirma_adres_q[OB+IW-1:OB]),
        .yaz_ofset_i     (sayac_q),
        .kelime_yaz_i    (kelime_yaz),
        .yaz_veri_i      (bellek_veri_i),
        .etiket_yaz_i    (son_vurus),
        .yaz_etiket_i    (kacirma_adres_q[31:OB+IW]),
        .gecerli_ayarla_i(!gecersiz_bayrak_q)
    );

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            durum_q <= BOSTA;
        else
            durum_q <= durum_d;
    end

    // next state and memory request strobe
    always_comb begin
        durum_d        = durum_q;
        bellek_istek_o = 1'b0;
        case (durum_q)
            BOSTA:   durum_d = istek_al && !isabet ? ISTEK : BOSTA;
            ISTEK: begin
                bellek_istek_o = 1'b1;
                durum_d        = bellek_hazir_i ? DOLDUR : ISTEK;
            end
            DOLDUR:  durum_d = son_vurus ? YANIT : DOLDUR;
            default: durum_d = BOSTA;
        endcase
    end

    // response, miss latch, beat counter and pending redirect bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hazir_q           <= 1'b0;
            buyruk_q          <= NOP;
            kacirma_adres_q   <= '0;
            bekleyen_v_q      <= 1'b0;
            bekleyen_adres_q  <= '0;
            sayac_q           <= '0;
            gecersiz_bayrak_q <= 1'b0;
            iptal_q           <= 1'b0;
        end else begin
            hazir_q <= istek_al && isabet;
            if (istek_al && isabet)
                buyruk_q <= okunan_kelime;
            if (son_vurus) begin
                hazir_q  <= !(iptal_q || ps_guncellendi_i);
                buyruk_q <= iletilen;
            end
            if (istek_al && !isabet) begin
                kacirma_adres_q   <= arama_adres;
                gecersiz_bayrak_q <= 1'b0;
                iptal_q           <= 1'b0;
            end
            if (durum_q != BOSTA && onbellek_gecersiz_i)
                gecersiz_bayrak_q <= 1'b1;
            if (durum_q != BOSTA && ps_guncellendi_i)
                iptal_q <= 1'b1;
            if (kelime_yaz)
                sayac_q <= sayac_q + 1'b1;
            if (ps_guncellendi_i && (durum_q != BOSTA || durdur_i || bekleyen_v_q)) begin
                bekleyen_v_q     <= 1'b1;
                bekleyen_adres_q <= buyruk_adres_i;
            end else if (istek_al) begin
                bekleyen_v_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_buyruk_onbellegi.sv
// tb_buyruk_onbellegi: directed vector bench for the instruction cache
module tb_buyruk_onbellegi;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] buyruk_adres_i = '0;
    logic        ps_guncellendi_i = 1'b0;
    logic        durdur_i = 1'b0;
    logic        onbellek_gecersiz_i = 1'b0;
    logic [31:0] buyruk_o;
    logic        buyruk_hazir_o;
    logic        bellek_istek_o;
    logic [31:0] bellek_adres_o;
    logic        bellek_hazir_i = 1'b0;
    logic        bellek_gecerli_i = 1'b0;
    logic [31:0] bellek_veri_i = '0;
    int          kontroller = 0;
    int          hatalar = 0;

    typedef struct {
        logic [31:0] adres;
        logic        ps;
        logic        durdur;
        logic        hazir;
        logic [31:0] buyruk;
    } vektor_t;
    vektor_t tablo [10];

    buyruk_onbellegi dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .buyruk_adres_i     (buyruk_adres_i),
        .ps_guncellendi_i   (ps_guncellendi_i),
        .durdur_i           (durdur_i),
        .onbellek_gecersiz_i(onbellek_gecersiz_i),
        .buyruk_o           (buyruk_o),
        .buyruk_hazir_o     (buyruk_hazir_o),
        .bellek_istek_o     (bellek_istek_o),
        .bellek_adres_o     (bellek_adres_o),
        .bellek_hazir_i     (bellek_hazir_i),
        .bellek_gecerli_i   (bellek_gecerli_i),
        .bellek_veri_i      (bellek_veri_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic cevrim();
        @(posedge clk_i);
        #1;
    endtask

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        kontroller++;
        if (gercek !== beklenen) begin
            hatalar++;
            $display("FAIL %s: gercek=%h beklenen=%h", ad, gercek, beklenen);
        end
    endtask

    task automatic cikis_kontrol(input string ad, input logic hazir, input logic [31:0] buyruk);
        kontrol({ad, "_hazir"}, 32'(buyruk_hazir_o), 32'(hazir));
        if (hazir)
            kontrol({ad, "_buyruk"}, buyruk_o, buyruk);
    endtask

    task automatic istek_kontrol(input string ad, input logic [31:0] adres);
        kontrol({ad, "_istek"}, 32'(bellek_istek_o), 32'd1);
        kontrol({ad, "_adres"}, bellek_adres_o, adres);
    endtask

    // accept the request, then deliver four beats (optional idle gaps, optional redirect to 0x100 on beat yon)
    task automatic dolum(input logic [31:0] taban, input bit bosluk, input int yon);
        bellek_hazir_i = 1'b1;
        cevrim();
        bellek_hazir_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bosluk && i > 0)
                cevrim();
            bellek_gecerli_i = 1'b1;
            bellek_veri_i    = taban | (i << 2);
            if (i == yon) begin
                ps_guncellendi_i = 1'b1;
                buyruk_adres_i   = 32'h100;
            end
            cevrim();
            bellek_gecerli_i = 1'b0;
            ps_guncellendi_i = 1'b0;
        end
    endtask

    task automatic kacirma(input logic [31:0] adres, input logic gecersiz, input logic [31:0] hat);
        cevrim();
        ps_guncellendi_i    = 1'b1;
        buyruk_adres_i      = adres;
        onbellek_gecersiz_i = gecersiz;
        @(negedge clk_i);
        cevrim();
        ps_guncellendi_i    = 1'b0;
        onbellek_gecersiz_i = 1'b0;
        @(negedge clk_i);
        istek_kontrol($sformatf("kacirma_%h", adres), hat);
    endtask

    initial begin
        tablo[0] = '{32'h104, 1'b1, 1'b0, 1'b0, 32'h0};
        tablo[1] = '{32'h108, 1'b1, 1'b0, 1'b1, 32'hA000_0104};
        tablo[2] = '{32'h10C, 1'b1, 1'b0, 1'b1, 32'hA000_0108};
        tablo[3] = '{32'h0,   1'b0, 1'b0, 1'b1, 32'hA000_010C};
        tablo[4] = '{32'h0,   1'b0, 1'b0, 1'b0, 32'h0};
        tablo[5] = '{32'h108, 1'b1, 1'b1, 1'b0, 32'h0};
        tablo[6] = '{32'h0,   1'b0, 1'b1, 1'b0, 32'h0};
        tablo[7] = '{32'h0,   1'b0, 1'b1, 1'b0, 32'h0};
        tablo[8] = '{32'h0,   1'b0, 1'b0, 1'b0, 32'h0};
        tablo[9] = '{32'h0,   1'b0, 1'b0, 1'b1, 32'hA000_0108};

        cevrim();
        cevrim();
        rst_i = 1'b0;
        @(negedge clk_i);
        kontrol("reset_hazir", 32'(buyruk_hazir_o), 32'd0);
        kontrol("reset_istek", 32'(bellek_istek_o), 32'd0);
        kontrol("reset_adres", bellek_adres_o, 32'h0);
        kontrol("reset_buyruk", buyruk_o, 32'h0000_0013);

        kacirma(32'h100, 1'b0, 32'h100);
        dolum(32'hA000_0100, 1'b0, -1);
        @(negedge clk_i);
        cikis_kontrol("ilk_dolum", 1'b1, 32'hA000_0100);

        for (int i = 0; i < 10; i++) begin
            cevrim();
            buyruk_adres_i   = tablo[i].adres;
            ps_guncellendi_i = tablo[i].ps;
            durdur_i         = tablo[i].durdur;
            @(negedge clk_i);
            cikis_kontrol($sformatf("tablo%0d", i), tablo[i].hazir, tablo[i].buyruk);
            kontrol($sformatf("tablo%0d_istek", i), 32'(bellek_istek_o), 32'd0);
        end
        cevrim();
        ps_guncellendi_i = 1'b0;
        durdur_i         = 1'b0;

        kacirma(32'h2000, 1'b0, 32'h2000);
        dolum(32'hB000_2000, 1'b0, 1);
        @(negedge clk_i);
        cikis_kontrol("yonlendir_yanit", 1'b0, 32'h0);
        cevrim();
        @(negedge clk_i);
        cikis_kontrol("yonlendir_y1", 1'b0, 32'h0);
        kontrol("yonlendir_y1_istek", 32'(bellek_istek_o), 32'd0);
        cevrim();
        @(negedge clk_i);
        cikis_kontrol("yonlendir_y2", 1'b1, 32'hA000_0100);
        cevrim();
        ps_guncellendi_i = 1'b1;
        buyruk_adres_i   = 32'h2008;
        @(negedge clk_i);
        cikis_kontrol("yonlendir_y3", 1'b0, 32'h0);
        cevrim();
        ps_guncellendi_i = 1'b0;
        @(negedge clk_i);
        cikis_kontrol("hat_2000_isabet", 1'b1, 32'hB000_2008);

        cevrim();
        onbellek_gecersiz_i = 1'b1;
        @(negedge clk_i);
        kacirma(32'h104, 1'b0, 32'h100);
        dolum(32'hA000_0100, 1'b1, -1);
        @(negedge clk_i);
        cikis_kontrol("gecersiz_dolum", 1'b1, 32'hA000_0104);

        kacirma(32'h10C, 1'b1, 32'h100);
        dolum(32'hA000_0100, 1'b0, -1);
        @(negedge clk_i);
        cikis_kontrol("esanli_gecersiz", 1'b1, 32'hA000_010C);

        kacirma(32'h3000, 1'b0, 32'h3000);
        bellek_hazir_i = 1'b1;
        cevrim();
        bellek_hazir_i   = 1'b0;
        bellek_gecerli_i = 1'b1;
        bellek_veri_i    = 32'hC000_3000;
        cevrim();
        bellek_veri_i = 32'hC000_3004;
        cevrim();
        rst_i         = 1'b1;
        bellek_veri_i = 32'hC000_3008;
        cevrim();
        rst_i         = 1'b0;
        bellek_veri_i = 32'hC000_300C;
        @(negedge clk_i);
        kontrol("ara_reset_hazir", 32'(buyruk_hazir_o), 32'd0);
        kontrol("ara_reset_istek", 32'(bellek_istek_o), 32'd0);
        kontrol("ara_reset_adres", bellek_adres_o, 32'h0);
        kontrol("ara_reset_buyruk", buyruk_o, 32'h0000_0013);
        cevrim();
        bellek_gecerli_i = 1'b0;
        @(negedge clk_i);
        kontrol("artik_vurus_istek", 32'(bellek_istek_o), 32'd0);
        kontrol("artik_vurus_hazir", 32'(buyruk_hazir_o), 32'd0);
        kacirma(32'h100, 1'b0, 32'h100);
        dolum(32'hA000_0100, 1'b0, -1);
        @(negedge clk_i);
        cikis_kontrol("reset_sonrasi_dolum", 1'b1, 32'hA000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", kontroller, hatalar);
        $finish;
    end
endmodule
